eeg_pea_out_arb: RTL and testbench

//  Round-robin write-back arbiter and layer-completion tracker for the PE-array engine outputs.

---
 rtl/eeg_pea_pkg.sv | 25 ++
 rtl/eeg_rr_arb.sv | 51 +++++
 rtl/eeg_pea_out_arb.sv | 176 +++++++++++++++++
 tb/tb_eeg_pea_out_arb.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eeg_pea_pkg.sv
// -----------------------------------------------------------------------------
// eeg_pea_pkg
// Shared types and helpers for the PE-array output write-back logic.
//   state_t : write-back FSM states (IDLE, RUN, DRAIN), 2-bit encoding
//   pe_num  : number of requesters for a PE_ROW x PE_COL array
//   idx_w   : width of a requester index, never less than 1 bit
// -----------------------------------------------------------------------------
package eeg_pea_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic int pe_num(input int rows, input int cols);
        return rows * cols;
    endfunction

    // A single requester still needs a 1-bit index so the bank field exists.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/eeg_rr_arb.sv
// -----------------------------------------------------------------------------
// eeg_rr_arb
// Purely combinational round-robin arbiter. Picks the first asserted request
// at or after the pointer, wrapping modulo N.
//   i_req     : request vector
//   i_ptr     : index with highest priority this cycle (must be < N)
//   o_gnt     : one-hot grant (all zero when nothing requests)
//   o_gnt_idx : binary index of the granted requester
//   o_any     : at least one request present
// -----------------------------------------------------------------------------
module eeg_rr_arb
    import eeg_pea_pkg::*;
#(
    parameter  int N  = 16,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_gnt_idx,
    output logic          o_any
);

    logic [2*N-1:0] w_dbl;
    logic [2*N-1:0] w_masked;

    // The request vector is duplicated; the lower copy is masked below the
    // pointer, so the lowest set bit of the result is the wrap-around winner.
    always_comb begin
        w_dbl = {i_req, i_req};
        for (int j = 0; j < 2*N; j++) begin
            w_masked[j] = w_dbl[j] && (j >= int'(i_ptr));
        end
    end

    always_comb begin
        o_any     = |w_masked;
        o_gnt_idx = '0;
        // Descending scan: the last hit written is the lowest set position.
        for (int j = 2*N-1; j >= 0; j--) begin
            if (w_masked[j]) begin
                o_gnt_idx = IW'(j % N);
            end
        end
        o_gnt = '0;
        if (o_any) begin
            o_gnt[o_gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/eeg_pea_out_arb.sv
// -----------------------------------------------------------------------------
// eeg_pea_out_arb
// Round-robin write-back arbiter and layer-completion tracker between the
// PE-array output streams and the single ORAM write port.
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   START             : arm a new layer, honoured only in IDLE
//   BUSY              : high in RUN or DRAIN
//   LAYER_DONE        : one-cycle pulse when the last beat of a layer leaves
//   BEAT_CNT          : beats accepted this layer, saturating
//   PE_OUT_VLD/LST    : per-PE valid and last-beat flags
//   PE_OUT_RDY        : per-PE ready, one-hot or zero
//   PE_OUT_DAT/ADD    : per-PE data and ORAM address, PE i at slice i
//   WR_VLD/RDY        : registered ORAM write handshake
//   WR_DAT/ADD/BNK    : write data, address and source PE (bank select)
// -----------------------------------------------------------------------------
module eeg_pea_out_arb
    import eeg_pea_pkg::*;
#(
    parameter  int PE_ROW      = 4,
    parameter  int PE_COL      = 4,
    parameter  int PE_OUT_DW   = 8,
    parameter  int ORAM_ADD_AW = 8,
    parameter  int CNT_DW      = 16,
    localparam int PE_NUM      = pe_num(PE_ROW, PE_COL),
    localparam int IDX_W       = idx_w(PE_NUM)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          START,
    output logic                          BUSY,
    output logic                          LAYER_DONE,
    output logic [CNT_DW-1:0]             BEAT_CNT,
    input  logic [PE_NUM-1:0]             PE_OUT_VLD,
    input  logic [PE_NUM-1:0]             PE_OUT_LST,
    output logic [PE_NUM-1:0]             PE_OUT_RDY,
    input  logic [PE_NUM*PE_OUT_DW-1:0]   PE_OUT_DAT,
    input  logic [PE_NUM*ORAM_ADD_AW-1:0] PE_OUT_ADD,
    output logic                          WR_VLD,
    input  logic                          WR_RDY,
    output logic [PE_OUT_DW-1:0]          WR_DAT,
    output logic [ORAM_ADD_AW-1:0]        WR_ADD,
    output logic [IDX_W-1:0]              WR_BNK
);

    function automatic logic [CNT_DW-1:0] sat_inc(input logic [CNT_DW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [IDX_W-1:0]         r_ptr;
    logic [PE_NUM-1:0]        r_mask;
    logic [CNT_DW-1:0]        r_cnt;
    logic                     r_wr_vld;
    logic [PE_OUT_DW-1:0]     r_wr_dat;
    logic [ORAM_ADD_AW-1:0]   r_wr_add;
    logic [IDX_W-1:0]         r_wr_bnk;

    logic                     w_load;
    logic                     w_start;
    logic                     w_any;
    logic                     w_grant;
    logic                     w_done;
    logic                     w_lst_sel;
    logic [PE_NUM-1:0]        w_elig;
    logic [PE_NUM-1:0]        w_gnt;
    logic [PE_NUM-1:0]        w_mask_nxt;
    logic [IDX_W-1:0]         w_gnt_idx;
    logic [IDX_W-1:0]         w_ptr_nxt;
    logic [PE_OUT_DW-1:0]     w_dat_sel;
    logic [ORAM_ADD_AW-1:0]   w_add_sel;

    // ---------------- arbitration (combinational, same cycle as RDY) ----------
    // The output register can take a beat when empty or draining this cycle.
    assign w_load  = !r_wr_vld || WR_RDY;
    assign w_start = (r_state == ST_IDLE) && START;
    // PEs that already delivered LST stay masked until the next START.
    assign w_elig  = (r_state == ST_RUN) ? (PE_OUT_VLD & ~r_mask) : '0;

    eeg_rr_arb #(
        .N (PE_NUM)
    ) u_arb (
        .i_req     (w_elig),
        .i_ptr     (r_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_any     (w_any)
    );

    assign w_grant    = w_load && w_any;
    assign PE_OUT_RDY = w_grant ? w_gnt : '0;

    // One-hot AND-OR select of the granted PE's fields.
    always_comb begin
        w_dat_sel = '0;
        w_add_sel = '0;
        w_lst_sel = 1'b0;
        for (int i = 0; i < PE_NUM; i++) begin
            if (w_gnt[i]) begin
                w_dat_sel = w_dat_sel | PE_OUT_DAT[i*PE_OUT_DW +: PE_OUT_DW];
                w_add_sel = w_add_sel | PE_OUT_ADD[i*ORAM_ADD_AW +: ORAM_ADD_AW];
                w_lst_sel = w_lst_sel | PE_OUT_LST[i];
            end
        end
    end

    assign w_mask_nxt = (w_grant && w_lst_sel) ? (r_mask | w_gnt) : r_mask;
    assign w_ptr_nxt  = (w_gnt_idx == IDX_W'(PE_NUM-1)) ? '0 : w_gnt_idx + 1'b1;

    // ---------------- FSM next state -----------------------------------------
    // RUN looks at the mask including this cycle's LST so that the final beat
    // drains in DRAIN and LAYER_DONE coincides with its write.
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (START) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (&w_mask_nxt) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_load) begin
                    w_state_nxt = ST_IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- registered state and write-back stage ------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_mask   <= '0;
            r_cnt    <= '0;
            r_wr_vld <= 1'b0;
            r_wr_dat <= '0;
            r_wr_add <= '0;
            r_wr_bnk <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_ptr <= w_ptr_nxt;
            end
            if (w_start) begin
                r_mask <= '0;
                r_cnt  <= '0;
            end else begin
                r_mask <= w_mask_nxt;
                if (w_grant) r_cnt <= sat_inc(r_cnt);
            end
            // A new grant replaces a draining beat with no bubble.
            if (w_grant) begin
                r_wr_vld <= 1'b1;
                r_wr_dat <= w_dat_sel;
                r_wr_add <= w_add_sel;
                r_wr_bnk <= w_gnt_idx;
            end else if (r_wr_vld && WR_RDY) begin
                r_wr_vld <= 1'b0;
            end
        end
    end

    assign WR_VLD     = r_wr_vld;
    assign WR_DAT     = r_wr_dat;
    assign WR_ADD     = r_wr_add;
    assign WR_BNK     = r_wr_bnk;
    assign BEAT_CNT   = r_cnt;
    assign BUSY       = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign LAYER_DONE = w_done;

endmodule

// File: tb/tb_eeg_pea_out_arb.sv
module tb_eeg_pea_out_arb;

    localparam int N  = 16;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            START;
    logic            BUSY;
    logic            LAYER_DONE;
    logic [CW-1:0]   BEAT_CNT;
    logic [N-1:0]    PE_OUT_VLD;
    logic [N-1:0]    PE_OUT_LST;
    logic [N-1:0]    PE_OUT_RDY;
    logic [N*DW-1:0] PE_OUT_DAT;
    logic [N*AW-1:0] PE_OUT_ADD;
    logic            WR_VLD;
    logic            WR_RDY;
    logic [DW-1:0]   WR_DAT;
    logic [AW-1:0]   WR_ADD;
    logic [3:0]      WR_BNK;

    always #5 clk = ~clk;

    eeg_pea_out_arb #(
        .PE_ROW(4), .PE_COL(4), .PE_OUT_DW(DW), .ORAM_ADD_AW(AW), .CNT_DW(CW)
    ) dut (
        .clk(clk), .rst(rst), .START(START), .BUSY(BUSY), .LAYER_DONE(LAYER_DONE),
        .BEAT_CNT(BEAT_CNT), .PE_OUT_VLD(PE_OUT_VLD), .PE_OUT_LST(PE_OUT_LST),
        .PE_OUT_RDY(PE_OUT_RDY), .PE_OUT_DAT(PE_OUT_DAT), .PE_OUT_ADD(PE_OUT_ADD),
        .WR_VLD(WR_VLD), .WR_RDY(WR_RDY), .WR_DAT(WR_DAT), .WR_ADD(WR_ADD), .WR_BNK(WR_BNK)
    );

    int n_err = 0;
    int n_chk = 0;

    // Per-PE beat sources: ring buffers of {lst, dat, add}.
    logic [16:0] pb [N][8];
    int          ph [N];
    int          pc [N];

    bit rdy, rdy_rand, start_next, start_cur, log_en;

    // Reference model of the spec's behaviour.
    int          m_state;   // 0 idle, 1 run, 2 drain
    int          m_ptr;
    bit [N-1:0]  m_mask;
    int          m_cnt;
    bit          m_vld;
    logic [7:0]  m_dat, m_add;
    int          m_bnk;
    int          e_g;
    bit          e_load, e_done, e_busy;
    logic [N-1:0] e_rdy;
    logic [54:0] exp_vec;
    wire  [54:0] obs_vec = {PE_OUT_RDY, WR_VLD, WR_BNK, WR_DAT, WR_ADD, BEAT_CNT, LAYER_DONE, BUSY};

    // Observation logs taken from the DUT pins.
    int         cyc = 0;
    int         dlog_bnk[$];
    int         dlog_cyc[$];
    logic [7:0] dlog_dat[$];
    int         done_cnt;
    int         done_cyc;

    function automatic void push(int i, bit l, logic [7:0] d, logic [7:0] a);
        pb[i][(ph[i] + pc[i]) % 8] = {l, d, a};
        pc[i]++;
    endfunction

    function automatic void clear_logs();
        dlog_bnk.delete(); dlog_cyc.delete(); dlog_dat.delete();
        done_cnt = 0; done_cyc = -1;
    endfunction

    function automatic void model_reset();
        m_state = 0; m_ptr = 0; m_mask = '0; m_cnt = 0;
        m_vld = 0; m_dat = '0; m_add = '0; m_bnk = 0;
        for (int i = 0; i < N; i++) begin ph[i] = 0; pc[i] = 0; end
    endfunction

    function automatic void drive();
        logic [31:0] r;
        for (int i = 0; i < N; i++) begin
            r = $urandom;
            if (pc[i] > 0) begin
                PE_OUT_VLD[i]         = 1'b1;
                PE_OUT_LST[i]         = pb[i][ph[i]][16];
                PE_OUT_DAT[i*DW +: DW] = pb[i][ph[i]][15:8];
                PE_OUT_ADD[i*AW +: AW] = pb[i][ph[i]][7:0];
            end else begin
                PE_OUT_VLD[i]         = 1'b0;
                PE_OUT_LST[i]         = r[16];
                PE_OUT_DAT[i*DW +: DW] = r[7:0];
                PE_OUT_ADD[i*AW +: AW] = r[15:8];
            end
        end
        r = $urandom;
        WR_RDY    = rdy_rand ? r[0] : rdy;
        START     = start_next;
        start_cur = start_next;
        start_next = 0;
    endfunction

    // Expected outputs for the current cycle, from model state and inputs.
    function automatic void model_eval();
        bit found;
        int j;
        e_load = !m_vld || WR_RDY;
        e_g = -1;
        found = 0;
        if (m_state == 1 && e_load) begin
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (!found && pc[j] > 0 && !m_mask[j]) begin
                    found = 1;
                    e_g = j;
                end
            end
        end
        e_rdy = '0;
        if (found) e_rdy[e_g] = 1'b1;
        e_done = (m_state == 2) && e_load;
        e_busy = (m_state != 0);
        exp_vec = {e_rdy, m_vld, m_bnk[3:0], m_dat, m_add, m_cnt[15:0], e_done, e_busy};
    endfunction

    function automatic void model_update();
        logic [16:0] b;
        if (e_g >= 0) begin
            b = pb[e_g][ph[e_g]];
            ph[e_g] = (ph[e_g] + 1) % 8;
            pc[e_g]--;
            m_vld = 1; m_dat = b[15:8]; m_add = b[7:0]; m_bnk = e_g;
            m_ptr = (e_g + 1) % N;
            if (m_cnt < 65535) m_cnt++;
            if (b[16]) m_mask[e_g] = 1'b1;
        end else if (m_vld && WR_RDY) begin
            m_vld = 0;
        end
        case (m_state)
            0: if (start_cur) begin m_state = 1; m_mask = '0; m_cnt = 0; end
            1: if (&m_mask) m_state = 2;
            2: if (e_load) m_state = 0;
            default: m_state = 0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
        drive();
        model_eval();
        @(negedge clk);
        if (log_en && WR_VLD && WR_RDY) begin
            dlog_bnk.push_back(int'(WR_BNK));
            dlog_cyc.push_back(cyc);
            dlog_dat.push_back(WR_DAT);
        end
        if (LAYER_DONE) begin done_cnt++; done_cyc = cyc; end
    endtask

    task automatic release_reset();
        model_reset();
        start_next = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive();
        model_eval();
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #2;
        n_chk++; if (WR_VLD !== 1'b0)      begin n_err++; $display("FAIL reset_wr_vld got=%b exp=0", WR_VLD); end
        n_chk++; if (WR_DAT !== '0)        begin n_err++; $display("FAIL reset_wr_dat got=%h exp=0", WR_DAT); end
        n_chk++; if (WR_ADD !== '0)        begin n_err++; $display("FAIL reset_wr_add got=%h exp=0", WR_ADD); end
        n_chk++; if (WR_BNK !== '0)        begin n_err++; $display("FAIL reset_wr_bnk got=%h exp=0", WR_BNK); end
        n_chk++; if (PE_OUT_RDY !== '0)    begin n_err++; $display("FAIL reset_rdy got=%h exp=0", PE_OUT_RDY); end
        n_chk++; if (BEAT_CNT !== '0)      begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", BEAT_CNT); end
        n_chk++; if (LAYER_DONE !== 1'b0)  begin n_err++; $display("FAIL reset_done got=%b exp=0", LAYER_DONE); end
        n_chk++; if (BUSY !== 1'b0)        begin n_err++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
        release_reset();
    endtask

    task automatic test_all_pes();
        clear_logs();
        for (int i = 0; i < N; i++) push(i, 1'b1, 8'(i), 8'(i));
        rdy = 1; start_next = 1;
        for (int k = 0; k < 22; k++) begin
            tick();
            n_chk++; if (obs_vec !== exp_vec) begin n_err++; $display("FAIL all_pes_cycle cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
        end
        n_chk++; if (dlog_bnk.size() != 16) begin n_err++; $display("FAIL all_pes_beats got=%0d exp=16", dlog_bnk.size()); end
        for (int k = 0; k < 16; k++) begin
            n_chk++;
            if (k >= dlog_bnk.size() || dlog_bnk[k] != k || dlog_cyc[k] != dlog_cyc[0] + k || dlog_dat[k] != 8'(k)) begin
                n_err++; $display("FAIL all_pes_order idx=%0d got_bnk=%0d exp_bnk=%0d", k, (k < dlog_bnk.size()) ? dlog_bnk[k] : -1, k);
            end
        end
        n_chk++; if (done_cnt != 1) begin n_err++; $display("FAIL all_pes_done_count got=%0d exp=1", done_cnt); end
        n_chk++; if (dlog_cyc.size() < 16 || done_cyc != dlog_cyc[15]) begin n_err++; $display("FAIL all_pes_done_cycle got=%0d exp=last drain", done_cyc); end
        n_chk++; if (BEAT_CNT !== 16'd16) begin n_err++; $display("FAIL all_pes_cnt got=%0d exp=16", BEAT_CNT); end
        n_chk++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL all_pes_busy got=%b exp=0", BUSY); end
    endtask

    task automatic test_alternation();
        logic [31:0] r;
        int alt [6] = '{3, 9, 3, 9, 3, 9};
        clear_logs();
        for (int i = 0; i < N; i++) begin
            int nb = (i == 3 || i == 9) ? 4 : 1;
            for (int b = 0; b < nb; b++) begin
                r = $urandom;
                push(i, b == nb - 1, r[7:0], r[15:8]);
            end
        end
        rdy = 1; start_next = 1;
        for (int k = 0; k < 30; k++) begin
            tick();
            n_chk++; if (obs_vec !== exp_vec) begin n_err++; $display("FAIL alt_cycle cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
        end
        n_chk++; if (dlog_bnk.size() != 22) begin n_err++; $display("FAIL alt_beats got=%0d exp=22", dlog_bnk.size()); end
        for (int k = 0; k < 6; k++) begin
            n_chk++;
            if (dlog_bnk.size() != 22 || dlog_bnk[16 + k] != alt[k]) begin
                n_err++; $display("FAIL alt_order idx=%0d got=%0d exp=%0d", 16 + k, (dlog_bnk.size() == 22) ? dlog_bnk[16 + k] : -1, alt[k]);
            end
        end
        n_chk++; if (BEAT_CNT !== 16'd22) begin n_err++; $display("FAIL alt_cnt got=%0d exp=22", BEAT_CNT); end
        n_chk++; if (done_cnt != 1) begin n_err++; $display("FAIL alt_done_count got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_backpressure();
        logic [31:0] r;
        logic [20:0] snap;
        bit [N-1:0] seen;
        clear_logs();
        for (int i = 0; i < N; i++) begin r = $urandom; push(i, 1'b1, r[7:0], r[15:8]); end
        rdy = 1; start_next = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_chk++; if (obs_vec !== exp_vec) begin n_err++; $display("FAIL bp_pre cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
        end
        rdy = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 0) snap = {WR_VLD, WR_BNK, WR_DAT, WR_ADD};
            n_chk++; if (obs_vec !== exp_vec) begin n_err++; $display("FAIL bp_hold_model cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
            n_chk++; if ({WR_VLD, WR_BNK, WR_DAT, WR_ADD} !== snap || WR_VLD !== 1'b1) begin n_err++; $display("FAIL bp_hold_stable cyc=%0d got=%h exp=%h", cyc, {WR_VLD, WR_BNK, WR_DAT, WR_ADD}, snap); end
            n_chk++; if (PE_OUT_RDY !== '0) begin n_err++; $display("FAIL bp_hold_rdy cyc=%0d got=%h exp=0", cyc, PE_OUT_RDY); end
        end
        rdy = 1;
        for (int k = 0; k < 25; k++) begin
            tick();
            n_chk++; if (obs_vec !== exp_vec) begin n_err++; $display("FAIL bp_post cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
        end
        seen = '0;
        foreach (dlog_bnk[k]) seen[dlog_bnk[k]] = 1'b1;
        n_chk++; if (dlog_bnk.size() != 16 || seen != '1) begin n_err++; $display("FAIL bp_no_loss beats=%0d seen=%h exp=16 all", dlog_bnk.size(), seen); end
        for (int k = 1; k < 16; k++) begin
            n_chk++;
            if (k >= dlog_cyc.size() || dlog_cyc[k] != dlog_cyc[1] + k - 1) begin
                n_err++; $display("FAIL bp_throughput idx=%0d got=%0d exp=%0d", k, (k < dlog_cyc.size()) ? dlog_cyc[k] : -1, (dlog_cyc.size() > 1) ? dlog_cyc[1] + k - 1 : -1);
            end
        end
    endtask

    task automatic test_lst_mask();
        logic [31:0] r;
        logic [7:0] d2;
        int n5;
        clear_logs();
        for (int i = 0; i < N; i++) begin r = $urandom; push(i, 1'b1, r[7:0], r[15:8]); end
        r = $urandom; d2 = r[7:0];
        push(5, 1'b1, d2, r[15:8]);
        rdy = 1; start_next = 1;
        for (int k = 0; k < 30; k++) begin
            tick();
            n_chk++; if (obs_vec !== exp_vec) begin n_err++; $display("FAIL mask_cycle cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
        end
        n5 = 0;
        foreach (dlog_bnk[k]) if (dlog_bnk[k] == 5) n5++;
        n_chk++; if (n5 != 1) begin n_err++; $display("FAIL mask_pe5_grants got=%0d exp=1", n5); end
        n_chk++; if (done_cnt != 1) begin n_err++; $display("FAIL mask_done_count got=%0d exp=1", done_cnt); end
        n_chk++; if (BEAT_CNT !== 16'd16) begin n_err++; $display("FAIL mask_cnt got=%0d exp=16", BEAT_CNT); end
        clear_logs();
        start_next = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_chk++; if (obs_vec !== exp_vec) begin n_err++; $display("FAIL mask_next_cycle cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
        end
        n_chk++; if (dlog_bnk.size() < 1 || dlog_bnk[0] != 5 || dlog_dat[0] !== d2) begin n_err++; $display("FAIL mask_next_first got_bnk=%0d exp=5", (dlog_bnk.size() > 0) ? dlog_bnk[0] : -1); end
    endtask

    task automatic test_start_ignored_and_reset();
        logic [31:0] r;
        int n5;
        clear_logs();
        r = $urandom; push(5, 1'b0, r[7:0], r[15:8]);
        start_next = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_chk++; if (obs_vec !== exp_vec) begin n_err++; $display("FAIL ign_cycle cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
        end
        n5 = 0;
        foreach (dlog_bnk[k]) if (dlog_bnk[k] == 5) n5++;
        n_chk++; if (BEAT_CNT !== 16'd1) begin n_err++; $display("FAIL ign_cnt got=%0d exp=1", BEAT_CNT); end
        n_chk++; if (BUSY !== 1'b1) begin n_err++; $display("FAIL ign_busy got=%b exp=1", BUSY); end
        n_chk++; if (n5 != 0) begin n_err++; $display("FAIL ign_pe5_masked got=%0d exp=0", n5); end
        r = $urandom; push(0, 1'b0, r[7:0], r[15:8]);
        rdy = 0;
        for (int k = 0; k < 3; k++) tick();
        n_chk++; if (WR_VLD !== 1'b1 || WR_BNK !== 4'd0) begin n_err++; $display("FAIL rst_pre_inflight got=%b/%0d exp=1/0", WR_VLD, WR_BNK); end
        rst = 1'b1;
        #1;
        n_chk++; if (obs_vec !== '0) begin n_err++; $display("FAIL rst_mid_outputs got=%h exp=0", obs_vec); end
        release_reset();
        clear_logs();
        for (int i = 0; i < N; i++) begin r = $urandom; push(i, 1'b1, r[7:0], r[15:8]); end
        rdy = 1; start_next = 1;
        for (int k = 0; k < 22; k++) begin
            tick();
            n_chk++; if (obs_vec !== exp_vec) begin n_err++; $display("FAIL rst_after_cycle cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
        end
        n_chk++; if (dlog_bnk.size() < 1 || dlog_bnk[0] != 0) begin n_err++; $display("FAIL rst_after_first got=%0d exp=0", (dlog_bnk.size() > 0) ? dlog_bnk[0] : -1); end
        n_chk++; if (done_cnt != 1 || BEAT_CNT !== 16'd16) begin n_err++; $display("FAIL rst_after_layer done=%0d cnt=%0d exp=1/16", done_cnt, BEAT_CNT); end
    endtask

    task automatic test_random();
        logic [31:0] r;
        int total;
        for (int l = 0; l < 3; l++) begin
            clear_logs();
            total = 0;
            for (int i = 0; i < N; i++) begin
                int nb = $urandom_range(1, 3);
                for (int b = 0; b < nb; b++) begin
                    r = $urandom;
                    push(i, b == nb - 1, r[7:0], r[15:8]);
                end
                total += nb;
            end
            rdy_rand = 1; start_next = 1;
            for (int k = 0; k < 200; k++) begin
                tick();
                n_chk++; if (obs_vec !== exp_vec) begin n_err++; $display("FAIL rand_cycle layer=%0d cyc=%0d got=%h exp=%h", l, cyc, obs_vec, exp_vec); end
            end
            rdy_rand = 0;
            n_chk++; if (done_cnt != 1) begin n_err++; $display("FAIL rand_done layer=%0d got=%0d exp=1", l, done_cnt); end
            n_chk++; if (BEAT_CNT !== CW'(total) || dlog_bnk.size() != total) begin n_err++; $display("FAIL rand_count layer=%0d got=%0d/%0d exp=%0d", l, BEAT_CNT, dlog_bnk.size(), total); end
        end
    endtask

    task automatic test_saturate();
        logic [31:0] r;
        log_en = 0;
        rdy = 1; start_next = 1;
        for (int k = 0; k < 65542; k++) begin
            if (pc[0] < 4) begin r = $urandom; push(0, 1'b0, r[7:0], r[15:8]); end
            tick();
            n_chk++; if (obs_vec !== exp_vec) begin n_err++; $display("FAIL sat_cycle cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
        end
        n_chk++; if (BEAT_CNT !== 16'hFFFF) begin n_err++; $display("FAIL sat_cnt got=%0d exp=65535", BEAT_CNT); end
        log_en = 1;
    endtask

    initial begin
        rst = 1'b0; rdy = 1; rdy_rand = 0; start_next = 0; log_en = 1;
        PE_OUT_VLD = '0; PE_OUT_LST = '0; PE_OUT_DAT = '0; PE_OUT_ADD = '0;
        model_reset();
        clear_logs();
        drive();
        test_reset();
        test_all_pes();
        test_alternation();
        test_backpressure();
        test_lst_mask();
        test_start_ignored_and_reset();
        test_random();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
